ncl_wavefront_sequencer: RTL and testbench
==========================================

// Module: ncl_wavefront_sequencer
// PURPOSE
// - Clocked controller that shares the input of a 4-rail (1-of-4) NCL pipeline between two requesters.
// - Injects DATA/NULL wavefronts per the completion protocol and drains the pipeline output.
// - Returns each result tagged with the id of the requester that issued it.
// - Sits between the synchronous host domain and the first and last pipeline stages.
// PARAMETERS
// - SYNC_STAGES  2  flops in each synchronizer on pipe_in_comp and pipe_out[3:0]; >=2
// - MAX_INFLIGHT 4  tag FIFO depth = max wavefronts in flight; power of 2, 2..16
// PORTS
// - clk            in   1     clock; all state on rising edge
// - init           in   1     reset, asynchronous, active-high
// - req0_valid     in   1     requester 0 has a symbol
// - req0_sym       in   2     requester 0 symbol 0..3
// - req0_ready     out  1     symbol accepted this cycle
// - req1_valid     in   1     requester 1 has a symbol
// - req1_sym       in   2     requester 1 symbol 0..3
// - req1_ready     out  1     symbol accepted this cycle
// - pipe_in        out  4     rails to first stage; 0000 = NULL, one-hot = DATA
// - pipe_in_comp   in   1     first-stage completion (async); 1 = DATA held, 0 = NULL held
// - pipe_out       in   4     rails from last stage (async)
// - pipe_out_comp  out  1     completion to last stage; 1 = DATA consumed, request NULL
// - rsp_valid      out  1     result available
// - rsp_id         out  1     requester that issued the result
// - rsp_sym        out  2     result symbol 0..3
// - rsp_ready      in   1     host takes result when rsp_valid & rsp_ready
// - inflight       out  5     wavefronts injected but not yet returned, 0..MAX_INFLIGHT
// - err            out  1     sticky illegal-rail flag (macro only; tied 0 otherwise)
// BEHAVIOUR
// - Reset values: pipe_in=0000, pipe_out_comp=0, req*_ready=0, rsp_valid=0, rsp_id=0, rsp_sym=0, inflight=0, err=0.
// - Reset state: IN_FSM=IDLE, OUT_FSM=WAIT_DATA, tag FIFO empty, round-robin pointer = requester 0.
// - Synchronizers: cin = synced pipe_in_comp; rout = synced pipe_out. Decisions use synced values only.
// - IN_FSM IDLE -> DATA:
//   - Requires: some reqN_valid, cin==0, tag FIFO not full.
//   - Grant round-robin; both valid -> requester != last granted.
//   - reqN_ready=1 for exactly that cycle.
//   - Register pipe_in = 1<<sym; push grant id into tag FIFO.
// - IN_FSM DATA -> NULL: hold pipe_in until cin==1, then pipe_in=0000.
// - IN_FSM NULL -> IDLE: hold NULL until cin==0.
// - Issue rate: at most one wavefront per full DATA/NULL cycle; no symbol accepted outside IDLE.
// - OUT_FSM WAIT_DATA -> WAIT_NULL:
//   - Requires: rout nonzero, rsp_valid==0 (or popped this cycle).
//   - Capture rsp_sym = index of the high rail; rsp_id = tag FIFO head.
//   - Pop tag FIFO, set rsp_valid, set pipe_out_comp=1.
//   - rsp_valid held high -> stay in WAIT_DATA with pipe_out_comp=0, stalling the pipeline (back-pressure).
// - OUT_FSM WAIT_NULL -> WAIT_DATA: when rout==0000, set pipe_out_comp=0.
// - rsp_valid clears on rsp_valid & rsp_ready. Output bus stable while rsp_valid & !rsp_ready.
// - inflight = tag FIFO count. Push and pop in the same cycle -> count unchanged.
// - Full: inflight==MAX_INFLIGHT -> no grants; pipe_in stays 0000.
// - Empty: rout DATA with tag FIFO empty is a protocol error. Capture with rsp_id=0, no pop (err under macro).
// - init mid-operation: all state/outputs to reset values at once; in-flight tags dropped.
//   - The pipeline must share the same init.
// CONFIGURATION
// - NCL_SEQ_ERRCHK_EN defined:
//   - Captured rout not exactly one-hot (2+ rails) -> err=1 (sticky until init); rsp_sym = lowest high rail.
//   - Tag-FIFO underflow -> err=1.
//   - Holding DATA/NULL in IN_FSM > 1024 cycles -> err=1 (stall watchdog).
// - NCL_SEQ_ERRCHK_EN undefined: no checking logic; err tied 0; rsp_sym = lowest high rail.
// TESTING
// - Single issue: req0 sym=2, pipeline 4 stages.
//   -> pipe_in=0100 then 0000; one rsp id=0 sym=2; inflight 1 then 0.
// - Contention: both valid every cycle, req0 syms 0,1,2, req1 syms 3,3,3.
//   -> grants alternate 0,1,0,1,0,1; responses in the same order with matching syms.
// - Back-pressure: rsp_ready=0 for 200 cycles, 8 requests.
//   -> inflight saturates at 4; no req*_ready while full.
//   -> pipe_out_comp stays 0 with rsp_valid held; after release, all 8 results arrive in order.
// - Reset mid-flight: assert init while IN_FSM=DATA and inflight=3.
//   -> next cycle all outputs are reset values; after release, a new req1 sym=1 returns id=1 sym=1.
// - Error (macro on): force pipe_out=0011.
//   -> err=1 and stays 1 through later clean traffic until init.

Source files
------------

// File: rtl/ncl_wavefront_sequencer.sv
// ncl_wavefront_sequencer
// Clocked controller for a 1-of-4 NCL pipeline. Two requesters share the
// pipeline input under round-robin arbitration. DATA/NULL wavefronts are
// sequenced from the first-stage completion, results are drained from the
// last stage, and each result is tagged with the id of its requester.
// Optional protocol checking (illegal rails, tag underflow, stall watchdog)
// is built when the macro NCL_SEQ_ERRCHK_EN is defined; otherwise err is 0.
module ncl_wavefront_sequencer #(
    parameter int SYNC_STAGES  = 2,
    parameter int MAX_INFLIGHT = 4
) (
    input  logic       clk,
    input  logic       init,
    input  logic       req0_valid,
    input  logic [1:0] req0_sym,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [1:0] req1_sym,
    output logic       req1_ready,
    output logic [3:0] pipe_in,
    input  logic       pipe_in_comp,
    input  logic [3:0] pipe_out,
    output logic       pipe_out_comp,
    output logic       rsp_valid,
    output logic       rsp_id,
    output logic [1:0] rsp_sym,
    input  logic       rsp_ready,
    output logic [4:0] inflight,
    output logic       err
);

    localparam int         PTR_W    = $clog2(MAX_INFLIGHT);
    localparam logic [4:0] FULL_CNT = 5'(MAX_INFLIGHT);

    typedef enum logic [1:0] {
        IN_IDLE = 2'd0,
        IN_DATA = 2'd1,
        IN_NULL = 2'd2
    } in_state_t;

    typedef enum logic {
        OUT_WAIT_DATA = 1'b0,
        OUT_WAIT_NULL = 1'b1
    } out_state_t;

    // Index of the lowest asserted rail; used for both legal and illegal codes.
    function automatic logic [1:0] f_low_rail(input logic [3:0] rails);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (rails[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    // Synchronizer flops
    logic [SYNC_STAGES-1:0]      r_cin_sync;
    logic [SYNC_STAGES-1:0][3:0] r_rout_sync;
    logic                        w_cin;
    logic [3:0]                  w_rout;

    // Input side
    in_state_t  r_in_state;
    in_state_t  w_in_next;
    logic [3:0] r_pipe_in;
    logic       r_rr_next;
    logic       w_grant;
    logic       w_grant_id;
    logic [1:0] w_grant_sym;

    // Tag FIFO
    logic             r_tag_mem [MAX_INFLIGHT];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [4:0]       r_count;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic             w_push;
    logic             w_pop;

    // Output side
    out_state_t r_out_state;
    out_state_t w_out_next;
    logic       w_capture;
    logic       r_rsp_valid;
    logic       r_rsp_id;
    logic [1:0] r_rsp_sym;

    assign w_cin        = r_cin_sync[SYNC_STAGES-1];
    assign w_rout       = r_rout_sync[SYNC_STAGES-1];
    assign w_fifo_full  = (r_count == FULL_CNT);
    assign w_fifo_empty = (r_count == 5'd0);

    // Bring the asynchronous completion and output rails into the clock domain.
    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            r_cin_sync  <= '0;
            r_rout_sync <= '0;
        end else begin
            r_cin_sync  <= {r_cin_sync[SYNC_STAGES-2:0], pipe_in_comp};
            r_rout_sync <= {r_rout_sync[SYNC_STAGES-2:0], pipe_out};
        end
    end

    // Arbitration: a grant needs an idle injector, a NULL-holding first stage
    // and room for the tag; contention goes to the requester not served last.
    always_comb begin
        w_grant     = 1'b0;
        w_grant_id  = 1'b0;
        w_grant_sym = req0_sym;
        if ((r_in_state == IN_IDLE) && !w_cin && !w_fifo_full &&
            (req0_valid || req1_valid)) begin
            w_grant = 1'b1;
            if (req0_valid && req1_valid) begin
                w_grant_id = r_rr_next;
            end else begin
                w_grant_id = req1_valid;
            end
            w_grant_sym = w_grant_id ? req1_sym : req0_sym;
        end
    end

    // Injector state register.
    always_ff @(posedge clk or posedge init) begin
        if (init) r_in_state <= IN_IDLE;
        else      r_in_state <= w_in_next;
    end

    // Injector next state: DATA held until the first stage completes, then
    // NULL held until the first stage clears.
    always_comb begin
        w_in_next = r_in_state;
        case (r_in_state)
            IN_IDLE: if (w_grant) w_in_next = IN_DATA;
            IN_DATA: if (w_cin)   w_in_next = IN_NULL;
            IN_NULL: if (!w_cin)  w_in_next = IN_IDLE;
            default:              w_in_next = IN_IDLE;
        endcase
    end

    // Injector outputs: ready pulses only in the grant cycle and never while init is held.
    always_comb begin
        req0_ready = w_grant && !w_grant_id && !init;
        req1_ready = w_grant &&  w_grant_id && !init;
    end

    // Registered input rails and round-robin pointer.
    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            r_pipe_in <= 4'b0000;
            r_rr_next <= 1'b0;
        end else begin
            if (w_grant) begin
                r_pipe_in <= 4'b0001 << w_grant_sym;
                r_rr_next <= ~w_grant_id;
            end else if ((r_in_state == IN_DATA) && w_cin) begin
                r_pipe_in <= 4'b0000;
            end
        end
    end

    assign w_push = w_grant;
    assign w_pop  = w_capture && !w_fifo_empty;

    // Tag storage is plain data and needs no reset; the pointers define validity.
    always_ff @(posedge clk) begin
        if (w_push) r_tag_mem[r_wr_ptr] <= w_grant_id;
    end

    // Tag FIFO pointers and occupancy; push and pop together leave the count alone.
    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= 5'd0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 5'd1;
                2'b01:   r_count <= r_count - 5'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // A result is taken only when the response slot is free or being emptied.
    assign w_capture = (r_out_state == OUT_WAIT_DATA) && (w_rout != 4'b0000) &&
                       (!r_rsp_valid || rsp_ready);

    // Drain state register.
    always_ff @(posedge clk or posedge init) begin
        if (init) r_out_state <= OUT_WAIT_DATA;
        else      r_out_state <= w_out_next;
    end

    // Drain next state: acknowledge DATA once captured, release on NULL.
    always_comb begin
        w_out_next = r_out_state;
        case (r_out_state)
            OUT_WAIT_DATA: if (w_capture)            w_out_next = OUT_WAIT_NULL;
            OUT_WAIT_NULL: if (w_rout == 4'b0000)    w_out_next = OUT_WAIT_DATA;
            default:                                 w_out_next = OUT_WAIT_DATA;
        endcase
    end

    // Drain output: completion is high exactly while waiting for NULL.
    always_comb begin
        pipe_out_comp = (r_out_state == OUT_WAIT_NULL);
    end

    // Response slot: loaded on capture, cleared on handshake, otherwise held stable.
    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= 1'b0;
            r_rsp_sym   <= 2'd0;
        end else if (w_capture) begin
            r_rsp_valid <= 1'b1;
            r_rsp_id    <= w_fifo_empty ? 1'b0 : r_tag_mem[r_rd_ptr];
            r_rsp_sym   <= f_low_rail(w_rout);
        end else if (r_rsp_valid && rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

`ifdef NCL_SEQ_ERRCHK_EN
    // More than one rail high is not a legal 1-of-4 code.
    function automatic logic f_multi_hot(input logic [3:0] rails);
        return (rails & (rails - 4'd1)) != 4'd0;
    endfunction

    logic [10:0] r_wd_cnt;
    logic        r_err;
    logic        w_stall;

    assign w_stall = (r_wd_cnt == 11'd1024);

    // Watchdog: cycles spent in the current DATA or NULL phase, saturating.
    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            r_wd_cnt <= 11'd0;
        end else if ((r_in_state == IN_IDLE) || (w_in_next != r_in_state)) begin
            r_wd_cnt <= 11'd0;
        end else if (r_wd_cnt != 11'd1025) begin
            r_wd_cnt <= r_wd_cnt + 11'd1;
        end
    end

    // Sticky error: illegal rails, result with no tag, or a stuck wavefront.
    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            r_err <= 1'b0;
        end else if ((w_capture && (f_multi_hot(w_rout) || w_fifo_empty)) || w_stall) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    assign pipe_in   = r_pipe_in;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_sym   = r_rsp_sym;
    assign inflight  = r_count;

endmodule

// File: tb/tb_ncl_wavefront_sequencer.sv
// Bench for ncl_wavefront_sequencer: a behavioural NCL pipeline model drives
// the completion side, scenario tasks drive the requesters and host, and
// results are checked against round-robin and in-order delivery rules.
module tb_ncl_wavefront_sequencer;

    localparam int MAXI = 4;

    logic       clk = 1'b0;
    logic       init = 1'b1;
    logic       req0_valid = 1'b0;
    logic [1:0] req0_sym = 2'd0;
    logic       req0_ready;
    logic       req1_valid = 1'b0;
    logic [1:0] req1_sym = 2'd0;
    logic       req1_ready;
    logic [3:0] pipe_in;
    logic       pipe_in_comp = 1'b0;
    logic [3:0] pipe_out = 4'b0000;
    logic       pipe_out_comp;
    logic       rsp_valid;
    logic       rsp_id;
    logic [1:0] rsp_sym;
    logic       rsp_ready = 1'b0;
    logic [4:0] inflight;
    logic       err;

    int n_cmp = 0;
    int n_bad = 0;

    // Pipeline model state
    int         depth = 4;
    logic [3:0] st [16];
    logic       force_en = 1'b0;
    logic [3:0] force_val = 4'b0000;

    // Stimulus queues and observations
    logic [1:0] q0 [$];
    logic [1:0] q1 [$];
    logic [4:0] grants [$];   // {v0, v1, id, sym}
    logic [2:0] rsps [$];     // {id, sym}
    int         rdy_mode = 0; // 0 always ready, 1 never, 2 random
    bit         rnd_req = 1'b0;
    int         max_inf = 0;
    int         full_viol = 0;
    int         stab_viol = 0;
    bit         poc_seen = 1'b0;
    bit         held = 1'b0;
    logic [2:0] held_val = 3'd0;

`ifdef NCL_SEQ_ERRCHK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    ncl_wavefront_sequencer #(.SYNC_STAGES(2), .MAX_INFLIGHT(MAXI)) dut (
        .clk(clk), .init(init),
        .req0_valid(req0_valid), .req0_sym(req0_sym), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_sym(req1_sym), .req1_ready(req1_ready),
        .pipe_in(pipe_in), .pipe_in_comp(pipe_in_comp),
        .pipe_out(pipe_out), .pipe_out_comp(pipe_out_comp),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_sym(rsp_sym), .rsp_ready(rsp_ready),
        .inflight(inflight), .err(err)
    );

    always #5 clk = ~clk;

    // Asynchronous NCL pipeline: each stage passes DATA when the next stage is
    // ready for data (holds NULL) and passes NULL when the next stage holds DATA.
    always begin
        #3;
        if (init) begin
            for (int i = 0; i < 16; i++) st[i] = 4'b0000;
        end else begin
            for (int i = depth - 1; i >= 0; i--) begin
                logic [3:0] din;
                logic       rfd;
                din = (i == 0) ? pipe_in : st[(i == 0) ? 0 : i - 1];
                rfd = (i == depth - 1) ? !pipe_out_comp : (st[(i == 15) ? 15 : i + 1] == 4'b0000);
                if (din != 4'b0000 && st[i] == 4'b0000 && rfd) st[i] = din;
                else if (din == 4'b0000 && st[i] != 4'b0000 && !rfd) st[i] = 4'b0000;
            end
        end
        pipe_in_comp = (st[0] != 4'b0000);
        pipe_out     = force_en ? force_val : st[depth - 1];
    end

    // One clock of stimulus: observe at the falling edge, drive after the rising edge.
    task automatic step();
        @(negedge clk);
        if (req0_ready) begin
            grants.push_back({req0_valid, req1_valid, 1'b0, req0_sym});
            void'(q0.pop_front());
        end
        if (req1_ready) begin
            grants.push_back({req0_valid, req1_valid, 1'b1, req1_sym});
            void'(q1.pop_front());
        end
        if (req0_ready && req1_ready) full_viol++;
        if ((req0_ready || req1_ready) && inflight >= 5'(MAXI)) full_viol++;
        if (rsp_valid && rsp_ready) rsps.push_back({rsp_id, rsp_sym});
        if (int'(inflight) > max_inf) max_inf = int'(inflight);
        if (held && (!rsp_valid || {rsp_id, rsp_sym} != held_val)) stab_viol++;
        held     = rsp_valid && !rsp_ready;
        held_val = {rsp_id, rsp_sym};
        if (pipe_out_comp) poc_seen = 1'b1;
        @(posedge clk);
        #1;
        req0_valid = (q0.size() > 0) && (!rnd_req || $urandom_range(0, 2) != 0);
        req0_sym   = (q0.size() > 0) ? q0[0] : 2'($urandom);
        req1_valid = (q1.size() > 0) && (!rnd_req || $urandom_range(0, 2) != 0);
        req1_sym   = (q1.size() > 0) ? q1[0] : 2'($urandom);
        rsp_ready  = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
    endtask

    task automatic apply_init(input int d);
        init       = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready  = 1'b0;
        force_en   = 1'b0;
        depth      = d;
        q0.delete(); q1.delete(); grants.delete(); rsps.delete();
        max_inf = 0; full_viol = 0; stab_viol = 0; poc_seen = 1'b0; held = 1'b0;
        rnd_req = 1'b0; rdy_mode = 0;
        repeat (3) @(posedge clk);
        #1;
        init = 1'b0;
    endtask

    task automatic test_reset();
        init = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (pipe_in !== 4'b0000)    begin n_bad++; $display("FAIL reset_pipe_in got %b want 0000", pipe_in); end
        n_cmp++; if (pipe_out_comp !== 1'b0) begin n_bad++; $display("FAIL reset_pipe_out_comp got %b want 0", pipe_out_comp); end
        n_cmp++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready got %b%b want 00", req0_ready, req1_ready); end
        n_cmp++; if (rsp_valid !== 1'b0)     begin n_bad++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
        n_cmp++; if ({rsp_id, rsp_sym} !== 3'd0) begin n_bad++; $display("FAIL reset_rsp_bus got %b want 000", {rsp_id, rsp_sym}); end
        n_cmp++; if (inflight !== 5'd0)      begin n_bad++; $display("FAIL reset_inflight got %0d want 0", inflight); end
        n_cmp++; if (err !== 1'b0)           begin n_bad++; $display("FAIL reset_err got %b want 0", err); end
        apply_init(4);
    endtask

    task automatic test_single_issue();
        apply_init(4);
        q0.push_back(2'd2);
        for (int c = 0; c < 100 && grants.size() == 0; c++) step();
        n_cmp++; if (grants.size() != 1) begin n_bad++; $display("FAIL single_grant got %0d grants want 1", grants.size()); end
        n_cmp++; if (pipe_in !== 4'b0100) begin n_bad++; $display("FAIL single_pipe_in_data got %b want 0100", pipe_in); end
        n_cmp++; if (inflight !== 5'd1)   begin n_bad++; $display("FAIL single_inflight_1 got %0d want 1", inflight); end
        for (int c = 0; c < 100 && pipe_in != 4'b0000; c++) step();
        n_cmp++; if (pipe_in !== 4'b0000) begin n_bad++; $display("FAIL single_pipe_in_null got %b want 0000", pipe_in); end
        for (int c = 0; c < 200 && rsps.size() == 0; c++) step();
        n_cmp++; if (rsps.size() != 1) begin n_bad++; $display("FAIL single_rsp_count got %0d want 1", rsps.size()); end
        else begin
            n_cmp++; if (rsps[0] !== 3'b010) begin n_bad++; $display("FAIL single_rsp got id=%b sym=%0d want id=0 sym=2", rsps[0][2], rsps[0][1:0]); end
        end
        repeat (10) step();
        n_cmp++; if (inflight !== 5'd0) begin n_bad++; $display("FAIL single_inflight_0 got %0d want 0", inflight); end
        n_cmp++; if (poc_seen !== 1'b1) begin n_bad++; $display("FAIL single_pipe_out_comp got never-high want pulse"); end
        n_cmp++; if (pipe_out_comp !== 1'b0) begin n_bad++; $display("FAIL single_poc_idle got %b want 0", pipe_out_comp); end
    endtask

    task automatic test_contention();
        logic [1:0] s0 [3];
        s0 = '{2'd0, 2'd1, 2'd2};
        apply_init(4);
        foreach (s0[k]) begin q0.push_back(s0[k]); q1.push_back(2'd3); end
        for (int c = 0; c < 600 && rsps.size() < 6; c++) step();
        n_cmp++; if (grants.size() != 6 || rsps.size() != 6) begin n_bad++; $display("FAIL contention_count got %0d/%0d want 6/6", grants.size(), rsps.size()); end
        else begin
            for (int k = 0; k < 6; k++) begin
                logic       eid;
                logic [1:0] esym;
                eid  = 1'(k % 2);
                esym = eid ? 2'd3 : s0[k / 2];
                n_cmp++; if (grants[k][2:0] !== {eid, esym}) begin n_bad++; $display("FAIL contention_grant%0d got id=%b sym=%0d want id=%b sym=%0d", k, grants[k][2], grants[k][1:0], eid, esym); end
                n_cmp++; if (rsps[k] !== {eid, esym}) begin n_bad++; $display("FAIL contention_rsp%0d got id=%b sym=%0d want id=%b sym=%0d", k, rsps[k][2], rsps[k][1:0], eid, esym); end
            end
        end
    endtask

    task automatic test_backpressure();
        logic pref;
        apply_init(8);
        for (int k = 0; k < 4; k++) begin q0.push_back(2'($urandom)); q1.push_back(2'($urandom)); end
        rdy_mode = 1;
        repeat (200) step();
        n_cmp++; if (max_inf != MAXI) begin n_bad++; $display("FAIL bp_saturate got %0d want %0d", max_inf, MAXI); end
        n_cmp++; if (full_viol != 0)  begin n_bad++; $display("FAIL bp_ready_while_full got %0d events want 0", full_viol); end
        n_cmp++; if (rsp_valid !== 1'b1 || pipe_out_comp !== 1'b0) begin n_bad++; $display("FAIL bp_stall got valid=%b comp=%b want 1/0", rsp_valid, pipe_out_comp); end
        n_cmp++; if (rsps.size() != 0) begin n_bad++; $display("FAIL bp_no_take got %0d want 0", rsps.size()); end
        rdy_mode = 0;
        for (int c = 0; c < 1500 && rsps.size() < 8; c++) step();
        n_cmp++; if (stab_viol != 0) begin n_bad++; $display("FAIL bp_stable got %0d changes want 0", stab_viol); end
        n_cmp++; if (grants.size() != 8 || rsps.size() != 8) begin n_bad++; $display("FAIL bp_count got %0d/%0d want 8/8", grants.size(), rsps.size()); end
        else begin
            pref = 1'b0;
            for (int k = 0; k < 8; k++) begin
                logic eid;
                eid = (grants[k][4] && grants[k][3]) ? pref : grants[k][3];
                n_cmp++; if (grants[k][2] !== eid) begin n_bad++; $display("FAIL bp_rr%0d got %b want %b", k, grants[k][2], eid); end
                pref = ~grants[k][2];
                n_cmp++; if (rsps[k] !== grants[k][2:0]) begin n_bad++; $display("FAIL bp_order%0d got %b want %b", k, rsps[k], grants[k][2:0]); end
            end
        end
    endtask

    task automatic test_reset_midflight();
        bit hit;
        hit = 1'b0;
        apply_init(8);
        for (int k = 0; k < 4; k++) begin q0.push_back(2'($urandom)); q1.push_back(2'($urandom)); end
        rdy_mode = 1;
        for (int c = 0; c < 400; c++) begin
            step();
            if (inflight == 5'd3 && pipe_in != 4'b0000) begin hit = 1'b1; break; end
        end
        n_cmp++; if (hit !== 1'b1) begin n_bad++; $display("FAIL midreset_reach got inflight=%0d pipe_in=%b want 3/DATA", inflight, pipe_in); end
        init = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if ({pipe_in, pipe_out_comp, rsp_valid, rsp_id, rsp_sym, err} !== 9'd0) begin n_bad++; $display("FAIL midreset_outputs got %b want 0", {pipe_in, pipe_out_comp, rsp_valid, rsp_id, rsp_sym, err}); end
        n_cmp++; if (inflight !== 5'd0) begin n_bad++; $display("FAIL midreset_inflight got %0d want 0", inflight); end
        apply_init(8);
        q1.push_back(2'd1);
        for (int c = 0; c < 300 && rsps.size() == 0; c++) step();
        n_cmp++; if (rsps.size() != 1 || rsps[0] !== 3'b101) begin n_bad++; $display("FAIL midreset_after got n=%0d rsp=%b want 1 rsp=101", rsps.size(), (rsps.size() > 0) ? rsps[0] : 3'bxxx); end
        repeat (5) step();
        n_cmp++; if (inflight !== 5'd0) begin n_bad++; $display("FAIL midreset_drained got %0d want 0", inflight); end
    endtask

    task automatic test_random_traffic();
        logic pref;
        for (int r = 0; r < 2; r++) begin
            apply_init($urandom_range(2, 8));
            for (int k = 0; k < 12; k++) begin q0.push_back(2'($urandom)); q1.push_back(2'($urandom)); end
            rnd_req = 1'b1; rdy_mode = 2;
            for (int c = 0; c < 4000 && rsps.size() < 24; c++) step();
            n_cmp++; if (grants.size() != 24 || rsps.size() != 24) begin n_bad++; $display("FAIL rand%0d_count got %0d/%0d want 24/24", r, grants.size(), rsps.size()); end
            else begin
                pref = 1'b0;
                for (int k = 0; k < 24; k++) begin
                    logic eid;
                    eid = (grants[k][4] && grants[k][3]) ? pref : grants[k][3];
                    n_cmp++; if (grants[k][2] !== eid) begin n_bad++; $display("FAIL rand%0d_rr%0d got %b want %b", r, k, grants[k][2], eid); end
                    pref = ~grants[k][2];
                    n_cmp++; if (rsps[k] !== grants[k][2:0]) begin n_bad++; $display("FAIL rand%0d_order%0d got %b want %b", r, k, rsps[k], grants[k][2:0]); end
                end
            end
            n_cmp++; if (max_inf > MAXI || full_viol != 0) begin n_bad++; $display("FAIL rand%0d_limit got max=%0d viol=%0d want <=%0d/0", r, max_inf, full_viol, MAXI); end
            n_cmp++; if (stab_viol != 0) begin n_bad++; $display("FAIL rand%0d_stable got %0d changes want 0", r, stab_viol); end
        end
    endtask

    task automatic test_error();
        apply_init(4);
        force_val = 4'b0011;
        force_en  = 1'b1;
        repeat (10) step();
        force_en = 1'b0;
        repeat (10) step();
        n_cmp++; if (rsps.size() != 1 || rsps[0] !== 3'b000) begin n_bad++; $display("FAIL err_capture got n=%0d rsp=%b want 1 rsp=000", rsps.size(), (rsps.size() > 0) ? rsps[0] : 3'bxxx); end
        n_cmp++; if (inflight !== 5'd0) begin n_bad++; $display("FAIL err_no_pop got %0d want 0", inflight); end
        n_cmp++; if (err !== ERR_EXP) begin n_bad++; $display("FAIL err_flag got %b want %b", err, ERR_EXP); end
        q0.push_back(2'd1);
        for (int c = 0; c < 200 && rsps.size() < 2; c++) step();
        n_cmp++; if (rsps.size() != 2 || rsps[1] !== 3'b001) begin n_bad++; $display("FAIL err_clean_rsp got n=%0d want 2 rsp=001", rsps.size()); end
        n_cmp++; if (err !== ERR_EXP) begin n_bad++; $display("FAIL err_sticky got %b want %b", err, ERR_EXP); end
        apply_init(4);
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL err_cleared got %b want 0", err); end
    endtask

    initial begin
        test_reset();
        test_single_issue();
        test_contention();
        test_backpressure();
        test_reset_midflight();
        test_random_traffic();
        test_error();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL global_timeout reached without finishing");
        $fatal(1);
    end

endmodule
